free_list: RTL and testbench

- Physical-register free list feeding the rename stage (RAT): each cycle it presents the next free physical register.
- Accepts physical registers released at commit.
- Checkpoints its read pointer into one of 8 pages on a branch (page numbers shared with RAT and branch buffer), and rewinds to a page on mispredict.
- Circular FIFO of 8-bit physical register numbers; initially holds phys 32..159 (0..31 are the reset architectural mappings).

---
 rtl/rename_pkg.sv | 16 +
 rtl/free_list_if.sv | 29 ++
 rtl/free_list_ckpt.sv | 28 ++
 rtl/free_list.sv | 78 +++++++
 tb/tb_free_list.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage types and constants, used by the free list, RAT and branch buffer.
package rename_pkg;
    localparam int PHYS_W   = 8;
    localparam int NUM_ARCH = 32;
    localparam int NUM_PHYS = 160;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PAGES    = 8;

    localparam logic [PHYS_W-1:0] PHY_NONE  = 8'hFF;
    localparam logic [PHYS_W-1:0] PHY_NOSRC = 8'hFE;

    typedef logic [PHYS_W-1:0] phys_t;
    typedef logic [2:0]        page_t;
    typedef logic [IDX_W:0]    ptr_t;
endpackage

// File: rtl/free_list_if.sv
// Rename/commit/branch-side port bundle of the physical-register free list.
interface free_list_if;
    logic                   alloc_req;
    rename_pkg::phys_t      free_phy_addr;
    logic                   free_valid;
    logic                   rel_valid;
    rename_pkg::phys_t      rel_addr;
    logic                   save_state;
    rename_pkg::page_t      save_page;
    logic                   restore_state;
    rename_pkg::page_t      restore_page;
    rename_pkg::ptr_t       count;
    logic                   empty;
    logic                   full;
    logic                   underflow;
    logic                   overflow;

    modport master (
        output alloc_req, rel_valid, rel_addr, save_state, save_page,
               restore_state, restore_page,
        input  free_phy_addr, free_valid, count, empty, full, underflow, overflow
    );

    modport slave (
        input  alloc_req, rel_valid, rel_addr, save_state, save_page,
               restore_state, restore_page,
        output free_phy_addr, free_valid, count, empty, full, underflow, overflow
    );
endinterface

// File: rtl/free_list_ckpt.sv
// Checkpoint file of free-list head pointers, one per branch page.
module free_list_ckpt
    import rename_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  save_state,
    input  page_t save_page,
    input  ptr_t  head_next,
    input  page_t restore_page,
    output ptr_t  ckpt_ptr
);

    ptr_t ckpt [PAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PAGES; i++) begin
                ckpt[i] <= '0;
            end
        end else if (save_state) begin
            ckpt[save_page] <= head_next;
        end
    end

    assign ckpt_ptr = ckpt[restore_page];

endmodule

// File: rtl/free_list.sv
// Physical-register free list: show-ahead circular FIFO with branch checkpoint/rewind of the head.
module free_list
    import rename_pkg::*;
(
    input logic       clk,
    input logic       reset,
    free_list_if.slave fl
);

    phys_t mem [DEPTH];
    ptr_t  head;
    ptr_t  tail;
    ptr_t  head_next;
    ptr_t  tail_next;
    ptr_t  cnt;
    ptr_t  cnt_next;
    ptr_t  ckpt_ptr;
    logic  rel_ok;
    logic  alloc_ok;
    logic  push;
    logic  underflow_q;
    logic  overflow_q;

    assign cnt              = tail - head;
    assign fl.count         = cnt;
    assign fl.empty         = (cnt == '0);
    assign fl.full          = (cnt == ptr_t'(DEPTH));
    assign fl.free_valid    = !fl.empty;
    assign fl.free_phy_addr = fl.empty ? PHY_NONE : mem[head[IDX_W-1:0]];
    assign fl.underflow     = underflow_q;
    assign fl.overflow      = overflow_q;

    // Sentinel numbers (x0, no-source, no-rd) are never real allocations.
    assign rel_ok = fl.rel_valid && (fl.rel_addr != '0) &&
                    (fl.rel_addr != PHY_NOSRC) && (fl.rel_addr != PHY_NONE);

    assign alloc_ok  = fl.alloc_req && !fl.restore_state && !fl.empty;
    assign push      = rel_ok && !fl.full;
    assign head_next = fl.restore_state ? ckpt_ptr : head + ptr_t'(alloc_ok);
    assign tail_next = tail + ptr_t'(push);
    assign cnt_next  = tail_next - head_next;

    free_list_ckpt u_ckpt (
        .clk          (clk),
        .reset        (reset),
        .save_state   (fl.save_state && !fl.restore_state),
        .save_page    (fl.save_page),
        .head_next    (head_next),
        .restore_page (fl.restore_page),
        .ckpt_ptr     (ckpt_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= ptr_t'(DEPTH);
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= phys_t'(NUM_ARCH + i);
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (push) begin
                mem[tail[IDX_W-1:0]] <= fl.rel_addr;
            end
            if (fl.alloc_req && !fl.restore_state && fl.empty) begin
                underflow_q <= 1'b1;
            end
            // A rewind to a stale page can leave more entries than the ring holds.
            if ((rel_ok && fl.full) || (fl.restore_state && (cnt_next > ptr_t'(DEPTH)))) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized rename/commit/branch traffic.
module tb_free_list;
    bit clk;
    bit reset;
    int vectors;
    int miscompares;

    free_list_if fl();

    free_list dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl)
    );

    always #5 clk = ~clk;

    // Reference model: absolute (unwrapped) head/tail sequence numbers over a 128-slot ring.
    int         m_head;
    int         m_tail;
    logic [7:0] m_mem [128];
    int         m_ck [8];
    bit         m_uf;
    bit         m_of;

    typedef struct {
        logic [7:0] phys;
        int         seq;
    } inflight_t;

    task automatic model_init();
        m_head = 0;
        m_tail = 128;
        for (int i = 0; i < 128; i++) m_mem[i] = 8'(32 + i);
        for (int p = 0; p < 8; p++) m_ck[p] = 0;
        m_uf = 0;
        m_of = 0;
    endtask

    function automatic int m_count();
        return (m_tail - m_head) & 255;
    endfunction

    function automatic logic [7:0] m_addr();
        return (m_count() == 0) ? 8'hFF : m_mem[m_head % 128];
    endfunction

    task automatic model_step(input bit a, input bit rv, input logic [7:0] ra,
                              input bit sv, input int sp, input bit rs, input int rp);
        int  cnt;
        bit  rel_ok;
        bit  a_ok;
        bit  pushed;
        int  hn;
        int  tn;
        cnt    = m_count();
        rel_ok = rv && (ra != 8'h00) && (ra != 8'hFE) && (ra != 8'hFF);
        a_ok   = a && !rs && (cnt != 0);
        pushed = rel_ok && (cnt != 128);
        hn     = rs ? m_ck[rp] : m_head + (a_ok ? 1 : 0);
        tn     = m_tail + (pushed ? 1 : 0);
        if (pushed) m_mem[m_tail % 128] = ra;
        if (a && !rs && cnt == 0) m_uf = 1;
        if ((rel_ok && cnt == 128) || (rs && (((tn - hn) & 255) > 128))) m_of = 1;
        if (sv && !rs) m_ck[sp] = hn;
        m_head = hn;
        m_tail = tn;
    endtask

    task automatic set_idle();
        fl.alloc_req     = 0;
        fl.rel_valid     = 0;
        fl.rel_addr      = 8'h00;
        fl.save_state    = 0;
        fl.save_page     = 3'd0;
        fl.restore_state = 0;
        fl.restore_page  = 3'd0;
    endtask

    // Apply one cycle of inputs (called at a negedge), return at the next negedge.
    task automatic tick(input bit a, input bit rv, input logic [7:0] ra,
                        input bit sv, input int sp, input bit rs, input int rp);
        fl.alloc_req     = a;
        fl.rel_valid     = rv;
        fl.rel_addr      = ra;
        fl.save_state    = sv;
        fl.save_page     = 3'(sp);
        fl.restore_state = rs;
        fl.restore_page  = 3'(rp);
        @(posedge clk);
        model_step(a, rv, ra, sv, sp, rs, rp);
        #1 set_idle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        model_init();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (fl.free_phy_addr !== 8'd32) begin miscompares++; $display("FAIL reset_addr: got %0d expected 32", fl.free_phy_addr); end
        vectors++; if (fl.free_valid !== 1'b1) begin miscompares++; $display("FAIL reset_valid: got %0b expected 1", fl.free_valid); end
        vectors++; if (fl.count !== 8'd128) begin miscompares++; $display("FAIL reset_count: got %0d expected 128", fl.count); end
        vectors++; if (fl.full !== 1'b1) begin miscompares++; $display("FAIL reset_full: got %0b expected 1", fl.full); end
        vectors++; if (fl.empty !== 1'b0) begin miscompares++; $display("FAIL reset_empty: got %0b expected 0", fl.empty); end
        vectors++; if (fl.underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %0b expected 0", fl.underflow); end
        vectors++; if (fl.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b expected 0", fl.overflow); end
    endtask

    task automatic test_alloc();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (fl.free_phy_addr !== 8'(32 + i)) begin miscompares++; $display("FAIL alloc_show_ahead[%0d]: got %0d expected %0d", i, fl.free_phy_addr, 32 + i); end
            tick(1, 0, 0, 0, 0, 0, 0);
        end
        vectors++; if (fl.free_phy_addr !== 8'd35) begin miscompares++; $display("FAIL alloc_after: got %0d expected 35", fl.free_phy_addr); end
        vectors++; if (fl.count !== 8'd125) begin miscompares++; $display("FAIL alloc_count: got %0d expected 125", fl.count); end
    endtask

    task automatic test_checkpoint();
        do_reset();
        repeat (2) tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 2, 0, 0);
        repeat (5) tick(1, 0, 0, 0, 0, 0, 0);
        vectors++; if (fl.free_phy_addr !== 8'd39) begin miscompares++; $display("FAIL ckpt_pre_restore_addr: got %0d expected 39", fl.free_phy_addr); end
        tick(0, 0, 0, 0, 0, 1, 2);
        vectors++; if (fl.free_phy_addr !== 8'd34) begin miscompares++; $display("FAIL ckpt_restore_addr: got %0d expected 34", fl.free_phy_addr); end
        vectors++; if (fl.count !== 8'd126) begin miscompares++; $display("FAIL ckpt_restore_count: got %0d expected 126", fl.count); end
        vectors++; if (fl.overflow !== 1'b0) begin miscompares++; $display("FAIL ckpt_restore_overflow: got %0b expected 0", fl.overflow); end
        // Same-cycle save and restore: save must be ignored, page 5 stays 0.
        tick(1, 0, 0, 1, 5, 1, 2);
        tick(0, 0, 0, 0, 0, 1, 5);
        vectors++; if (fl.free_phy_addr !== 8'd32) begin miscompares++; $display("FAIL ckpt_save_blocked: got %0d expected 32", fl.free_phy_addr); end
    endtask

    task automatic test_empty();
        do_reset();
        repeat (128) tick(1, 0, 0, 0, 0, 0, 0);
        vectors++; if (fl.empty !== 1'b1) begin miscompares++; $display("FAIL empty_flag: got %0b expected 1", fl.empty); end
        vectors++; if (fl.free_phy_addr !== 8'hFF) begin miscompares++; $display("FAIL empty_addr: got %0h expected ff", fl.free_phy_addr); end
        vectors++; if (fl.free_valid !== 1'b0) begin miscompares++; $display("FAIL empty_valid: got %0b expected 0", fl.free_valid); end
        vectors++; if (fl.underflow !== 1'b0) begin miscompares++; $display("FAIL empty_no_uf_yet: got %0b expected 0", fl.underflow); end
        tick(1, 0, 0, 0, 0, 0, 0);
        vectors++; if (fl.underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_flag: got %0b expected 1", fl.underflow); end
        vectors++; if (fl.count !== 8'd0) begin miscompares++; $display("FAIL underflow_count: got %0d expected 0", fl.count); end
        tick(1, 1, 8'd5, 0, 0, 0, 0);
        vectors++; if (fl.free_phy_addr !== 8'd5) begin miscompares++; $display("FAIL release_addr: got %0d expected 5", fl.free_phy_addr); end
        vectors++; if (fl.count !== 8'd1) begin miscompares++; $display("FAIL release_nobypass_count: got %0d expected 1", fl.count); end
    endtask

    task automatic test_overflow();
        do_reset();
        tick(0, 1, 8'd40, 0, 0, 0, 0);
        vectors++; if (fl.overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_flag: got %0b expected 1", fl.overflow); end
        vectors++; if (fl.count !== 8'd128) begin miscompares++; $display("FAIL overflow_count: got %0d expected 128", fl.count); end
        do_reset();
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 8'h00, 0, 0, 0, 0);
        tick(0, 1, 8'hFE, 0, 0, 0, 0);
        tick(0, 1, 8'hFF, 0, 0, 0, 0);
        vectors++; if (fl.count !== 8'd127) begin miscompares++; $display("FAIL sentinel_count: got %0d expected 127", fl.count); end
        vectors++; if (fl.overflow !== 1'b0) begin miscompares++; $display("FAIL sentinel_flag: got %0b expected 0", fl.overflow); end
        tick(0, 1, 8'hFF, 0, 0, 0, 0);
        tick(0, 1, 8'd40, 0, 0, 0, 0);
        tick(0, 1, 8'hFE, 0, 0, 0, 0);
        vectors++; if (fl.full !== 1'b1) begin miscompares++; $display("FAIL refill_full: got %0b expected 1", fl.full); end
        vectors++; if (fl.overflow !== 1'b0) begin miscompares++; $display("FAIL sentinel_full_flag: got %0b expected 0", fl.overflow); end
        vectors++; if (fl.free_phy_addr !== 8'd33) begin miscompares++; $display("FAIL refill_addr: got %0d expected 33", fl.free_phy_addr); end
    endtask

    task automatic test_restore_combo();
        do_reset();
        repeat (2) tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 2, 0, 0);
        repeat (3) tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 1, 8'd7, 0, 0, 1, 2);
        vectors++; if (fl.free_phy_addr !== 8'd34) begin miscompares++; $display("FAIL combo_addr: got %0d expected 34", fl.free_phy_addr); end
        vectors++; if (fl.count !== 8'd127) begin miscompares++; $display("FAIL combo_count: got %0d expected 127", fl.count); end
        vectors++; if (fl.underflow !== 1'b0) begin miscompares++; $display("FAIL combo_underflow: got %0b expected 0", fl.underflow); end
        tick(0, 1, 8'd40, 0, 0, 0, 0);
        tick(0, 1, 8'd41, 0, 0, 0, 0);
        vectors++; if (fl.overflow !== 1'b1) begin miscompares++; $display("FAIL combo_overflow: got %0b expected 1", fl.overflow); end
        // Asynchronous reset in the middle of a cycle with an alloc pending.
        fl.alloc_req = 1;
        @(posedge clk);
        #2 reset = 1;
        #1;
        vectors++; if (fl.free_phy_addr !== 8'd32) begin miscompares++; $display("FAIL async_reset_addr: got %0d expected 32", fl.free_phy_addr); end
        vectors++; if (fl.count !== 8'd128) begin miscompares++; $display("FAIL async_reset_count: got %0d expected 128", fl.count); end
        vectors++; if (fl.overflow !== 1'b0) begin miscompares++; $display("FAIL async_reset_overflow: got %0b expected 0", fl.overflow); end
        set_idle();
        model_init();
        @(negedge clk);
        reset = 0;
        tick(1, 0, 0, 0, 0, 0, 0);
        vectors++; if (fl.free_phy_addr !== 8'd33) begin miscompares++; $display("FAIL post_reset_alloc: got %0d expected 33", fl.free_phy_addr); end
        tick(0, 0, 0, 0, 0, 1, 2);
        vectors++; if (fl.free_phy_addr !== 8'd32) begin miscompares++; $display("FAIL post_reset_ckpt: got %0d expected 32", fl.free_phy_addr); end
    endtask

    task automatic test_restore_overflow();
        do_reset();
        tick(0, 0, 0, 1, 1, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 8'd50, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 1);
        vectors++; if (fl.overflow !== 1'b1) begin miscompares++; $display("FAIL restore_overflow_flag: got %0b expected 1", fl.overflow); end
        vectors++; if (fl.count !== 8'd129) begin miscompares++; $display("FAIL restore_overflow_count: got %0d expected 129", fl.count); end
    endtask

    task automatic test_random();
        inflight_t  q[$];
        bit         pvalid [8];
        bit         a, rv, sv, rs;
        logic [7:0] ra;
        int         sp, rp, seq, ck, cnt;
        logic [7:0] sentinels [3];
        sentinels[0] = 8'h00;
        sentinels[1] = 8'hFE;
        sentinels[2] = 8'hFF;
        do_reset();
        for (int p = 0; p < 8; p++) pvalid[p] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vectors++; if (fl.count !== 8'(m_count())) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, fl.count, m_count()); end
            vectors++; if (fl.free_phy_addr !== m_addr()) begin miscompares++; $display("FAIL rnd_addr@%0d: got %0d expected %0d", cyc, fl.free_phy_addr, m_addr()); end
            vectors++; if (fl.empty !== (m_count() == 0) || fl.full !== (m_count() == 128) || fl.free_valid !== (m_count() != 0)) begin miscompares++; $display("FAIL rnd_status@%0d: got e%0b f%0b v%0b expected count %0d", cyc, fl.empty, fl.full, fl.free_valid, m_count()); end
            vectors++; if (fl.underflow !== m_uf || fl.overflow !== m_of) begin miscompares++; $display("FAIL rnd_flags@%0d: got uf%0b of%0b expected uf%0b of%0b", cyc, fl.underflow, fl.overflow, m_uf, m_of); end
            vectors++; if (int'(fl.count) + q.size() != 128) begin miscompares++; $display("FAIL rnd_invariant@%0d: got free %0d + inflight %0d expected 128", cyc, fl.count, q.size()); end

            cnt = m_count();
            a   = ($urandom_range(99) < 55);
            rv  = 0;
            ra  = 8'h00;
            if (q.size() > 0 && $urandom_range(99) < 45) begin
                rv  = 1;
                ra  = q[0].phys;
                seq = q[0].seq;
                void'(q.pop_front());
                for (int p = 0; p < 8; p++) if (pvalid[p] && m_ck[p] <= seq) pvalid[p] = 0;
            end else if ($urandom_range(99) < 5) begin
                rv = 1;
                ra = sentinels[$urandom_range(2)];
            end
            rp = $urandom_range(7);
            rs = pvalid[rp] && ($urandom_range(99) < 8);
            sv = ($urandom_range(99) < 12);
            sp = $urandom_range(7);
            if (rs) begin
                ck = m_ck[rp];
                while (q.size() > 0 && q[q.size()-1].seq >= ck) void'(q.pop_back());
                for (int p = 0; p < 8; p++) if (pvalid[p] && m_ck[p] > ck) pvalid[p] = 0;
            end else if (a && cnt != 0) begin
                q.push_back('{phys: m_addr(), seq: m_head});
            end
            tick(a, rv, ra, sv, sp, rs, rp);
            if (sv && !rs) pvalid[sp] = 1;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1;
        set_idle();
        model_init();
        test_reset();
        test_alloc();
        test_checkpoint();
        test_empty();
        test_overflow();
        test_restore_combo();
        test_restore_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
